hp_timer: RTL and testbench
===========================

# hp_timer

Companion block to the game controller FSM. Consumes its registered `STATE` code and produces the two status inputs the controller waits on in its result states: `CNT1S`, the one-second dwell pulse, and `HP_IN`, the knockout flag. It also holds both players' hit points for the display path. It sits directly downstream of the controller's `STATE` register and feeds back into its next-state logic.

## Interface
- `TICKS_PER_SEC`, 50_000_000: CLK cycles per second of dwell; must be ≥ 4.
- `HP_INIT`, 3: starting HP per player; range 1..(2^HP_W − 1).
- `HP_W`, 3: HP counter width.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `STATE` in 4: controller state code.
- `CNT1S` out 1: one-cycle pulse marking the end of the result-state dwell.
- `HP_IN` out 2: {own HP is 0, opponent HP is 0}:
  - 00: nobody out.
  - 01: opponent out.
  - 10: player out.
- `HP_P1` out HP_W: player's own HP.
- `HP_P2` out HP_W: opponent HP.

## Operation
- State codes:
  - READY 4'h2, QUESTION 4'h3, INPUT 4'h4.
  - DRAW 4'h6, WRONG 4'h7, GOOD 4'h8, OUCH 4'h9, WIN 4'hA, LOSE 4'hB.
  - The result set is {6, 7, 8, 9, A, B}.
- `prev_state` register, reset to READY. Entry event: `STATE != prev_state`.
- Damage, applied on the edge following an entry event:
  - Entry into GOOD: `HP_P2` −1.
  - Entry into OUCH: `HP_P1` −1.
  - Both saturate at 0, never wrap.
  - DRAW, WRONG, WIN and LOSE change no HP.
  - Only one entry event is possible per cycle, so simultaneous damage cannot occur.
- Game restart: entry into READY with `prev_state` ∈ {WIN, LOSE} reloads both HP counters to `HP_INIT`. Entry into READY from any other state leaves HP unchanged.
- `HP_IN` is combinational from the HP registers: {`HP_P1`==0, `HP_P2`==0}. The value 11 is unreachable.
- Dwell timer:
  - Cycle counter `cnt`, width clog2(period).
  - Cleared on any entry event and whenever `STATE` is outside the result set.
  - Otherwise increments.
  - When `cnt` == period−1, `CNT1S` = 1 for that cycle and `cnt` wraps to 0.
  - `CNT1S` is combinational from `cnt`.
- `STATE` codes outside the list are treated as non-result: timer held clear, HP unchanged.
- Reset values, applied asynchronously while `RST` is high:
  - `HP_P1` = `HP_P2` = `HP_INIT`, `HP_IN` = 00.
  - `cnt` = 0, `CNT1S` = 0, `prev_state` = READY.

## Timing
- HP latency: `HP_P*` and `HP_IN` update 1 cycle after `STATE` first shows GOOD or OUCH.
  - This is well before `CNT1S` (period ≥ 4), so the controller's WIN/LOSE check sees valid `HP_IN`.
- `CNT1S` latency: first pulse exactly `period` cycles after `STATE` first shows a result code.
  - The controller takes 2 further cycles to change `STATE`.
  - Because period ≥ 4, no second pulse can occur before the exit.
- Leaving the result set mid-count: `cnt` clears on the next edge and no pulse is issued. Re-entry restarts a full period.
- Direct result→result transition (GOOD→WIN, OUCH→LOSE): the entry event restarts the full period for the new state.
- `RST` asserted mid-dwell: immediate clear, no pulse. On release, operation resumes from the first rising edge after deassertion.

## Configuration
- `HPTIMER_SIM_FAST_EN`:
  - Defined: period = 8 cycles, `TICKS_PER_SEC` ignored. Intended for simulation of full games.
  - Undefined: period = `TICKS_PER_SEC`.

## Structure
- Shared package `game_pkg` holds:
  - The 4-bit state code localparams: READY … LOSE.
  - `HP_IN` encodings: HP_NONE = 2'b00, HP_OPP_OUT = 2'b01, HP_OWN_OUT = 2'b10.
  - The result-set membership function.
- The controller imports the same package.
- One sub-module, `sec_timer`:
  - Ports: CLK, RST, clear, run, pulse.
  - Parameter: PERIOD.
  - Contains the dwell counter.
- HP logic and entry detection stay in `hp_timer`.

## Test plan
- Assert `RST` with `STATE`=4'h4 → `HP_P1`=`HP_P2`=3, `HP_IN`=00, `CNT1S`=0, all immediately and without waiting for a clock edge.
- `STATE` 4→8 held (FAST) → `HP_P2`=2 one cycle after entry; single `CNT1S` pulse on cycle 8 after entry; no pulse on cycles 9–15 while held.
- Three GOOD entries separated by READY → `HP_P2`=0, `HP_IN`=01. A fourth GOOD leaves `HP_P2`=0. `STATE` A→2 → both HP=3, `HP_IN`=00.
- Three OUCH entries → `HP_P1`=0, `HP_IN`=10. `STATE` B→2 reloads both HP to 3. `STATE` 7→4 reloads nothing.
- `STATE`=8 for 3 cycles then 2 → no `CNT1S`. `STATE`=8 again → pulse 8 cycles after re-entry. `STATE` 8→A direct → `cnt` restarts, pulse 8 cycles after the A entry.
- `RST` pulsed at cycle 5 of a GOOD dwell → no `CNT1S`, HP restored to 3. A fresh GOOD entry after release → full 8-cycle dwell.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: controller state codes, HP_IN encodings and the
// result-state membership test used by both the controller and hp_timer.
package game_pkg;

  localparam logic [3:0] READY    = 4'h2;
  localparam logic [3:0] QUESTION = 4'h3;
  localparam logic [3:0] INPUT    = 4'h4;
  localparam logic [3:0] DRAW     = 4'h6;
  localparam logic [3:0] WRONG    = 4'h7;
  localparam logic [3:0] GOOD     = 4'h8;
  localparam logic [3:0] OUCH     = 4'h9;
  localparam logic [3:0] WIN      = 4'hA;
  localparam logic [3:0] LOSE     = 4'hB;

  localparam logic [1:0] HP_NONE    = 2'b00;
  localparam logic [1:0] HP_OPP_OUT = 2'b01;
  localparam logic [1:0] HP_OWN_OUT = 2'b10;

  function automatic logic is_result(input logic [3:0] code);
    logic res;
    case (code)
      DRAW, WRONG, GOOD, OUCH, WIN, LOSE: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Free-running dwell counter: counts while run is high, pulses on the last
// count of each PERIOD and wraps; clear forces it back to zero.
module sec_timer #(
  parameter int unsigned PERIOD = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic pulse
);

  localparam int unsigned CntW = $clog2(PERIOD);
  localparam logic [CntW-1:0] Last = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pulse = (cnt_q == Last);

endmodule

// File: rtl/hp_timer.sv
// Hit-point bookkeeping and result-state dwell timer for the game controller.
// Define HPTIMER_SIM_FAST_EN to shorten the dwell to 8 cycles for simulation.
module hp_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned HP_INIT       = 3,
  parameter int unsigned HP_W          = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      STATE,
  output logic            CNT1S,
  output logic [1:0]      HP_IN,
  output logic [HP_W-1:0] HP_P1,
  output logic [HP_W-1:0] HP_P2
);

  import game_pkg::*;

`ifdef HPTIMER_SIM_FAST_EN
  localparam int unsigned Period = 8;
`else
  localparam int unsigned Period = TICKS_PER_SEC;
`endif

  localparam logic [HP_W-1:0] HpInit = HP_W'(HP_INIT);

  logic [3:0]      prev_state_q;
  logic [HP_W-1:0] hp_p1_q, hp_p1_d;
  logic [HP_W-1:0] hp_p2_q, hp_p2_d;
  logic            entry;
  logic            in_result;

  assign entry     = (STATE != prev_state_q);
  assign in_result = is_result(STATE);

  always_comb begin
    hp_p1_d = hp_p1_q;
    hp_p2_d = hp_p2_q;
    if (entry) begin
      case (STATE)
        GOOD: if (hp_p2_q != '0) hp_p2_d = hp_p2_q - HP_W'(1);
        OUCH: if (hp_p1_q != '0) hp_p1_d = hp_p1_q - HP_W'(1);
        // Only a return to READY from a finished game starts a new one
        READY: begin
          if (prev_state_q == WIN || prev_state_q == LOSE) begin
            hp_p1_d = HpInit;
            hp_p2_d = HpInit;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_state_q <= READY;
      hp_p1_q      <= HpInit;
      hp_p2_q      <= HpInit;
    end else begin
      prev_state_q <= STATE;
      hp_p1_q      <= hp_p1_d;
      hp_p2_q      <= hp_p2_d;
    end
  end

  always_comb begin
    HP_IN = HP_NONE;
    if (hp_p1_q == '0) HP_IN = HP_IN | HP_OWN_OUT;
    if (hp_p2_q == '0) HP_IN = HP_IN | HP_OPP_OUT;
  end

  assign HP_P1 = hp_p1_q;
  assign HP_P2 = hp_p2_q;

  sec_timer #(
    .PERIOD(Period)
  ) u_sec_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clear(entry | ~in_result),
    .run  (in_result),
    .pulse(CNT1S)
  );

endmodule

// File: tb/tb_hp_timer.sv
// Self-checking bench for hp_timer with an 8-cycle dwell period.
module tb_hp_timer;

  localparam int P    = 8;
  localparam int HPI  = 3;
  localparam int HP_W = 3;

  logic            CLK;
  logic            RST;
  logic [3:0]      STATE;
  logic            CNT1S;
  logic [1:0]      HP_IN;
  logic [HP_W-1:0] HP_P1;
  logic [HP_W-1:0] HP_P2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: HP per player, last STATE value seen at an edge, and
  // how many edges that value has been held.
  int         m_p1, m_p2, m_age;
  logic [3:0] m_prev;

  hp_timer #(
    .TICKS_PER_SEC(P),
    .HP_INIT      (HPI),
    .HP_W         (HP_W)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .STATE(STATE),
    .CNT1S(CNT1S),
    .HP_IN(HP_IN),
    .HP_P1(HP_P1),
    .HP_P2(HP_P2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic res_code(input logic [3:0] s);
    return (s >= 4'h6) && (s <= 4'hB);
  endfunction

  function automatic logic exp_pulse();
    return res_code(m_prev) && (m_age > 0) && (m_age % P == 0);
  endfunction

  function automatic logic [1:0] exp_hp_in();
    return {m_p1 == 0, m_p2 == 0};
  endfunction

  function automatic logic [9:0] exp_all();
    return {exp_pulse(), exp_hp_in(), HP_W'(m_p1), HP_W'(m_p2)};
  endfunction

  task automatic model_reset();
    m_p1   = HPI;
    m_p2   = HPI;
    m_prev = 4'h2;
    m_age  = 0;
  endtask

  // Drive one cycle of STATE, advance the model at the edge, sample #1 later.
  task automatic step(input logic [3:0] s);
    STATE = s;
    @(posedge CLK);
    if (s != m_prev) begin
      if (s == 4'h8) begin
        if (m_p2 > 0) m_p2--;
      end else if (s == 4'h9) begin
        if (m_p1 > 0) m_p1--;
      end else if (s == 4'h2 && (m_prev == 4'hA || m_prev == 4'hB)) begin
        m_p1 = HPI;
        m_p2 = HPI;
      end
      m_prev = s;
      m_age  = 1;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic test_reset();
    STATE = 4'h4;
    RST   = 1'b0;
    #1 RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (HP_P1 !== 3'd3 || HP_P2 !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_hp: got p1=%0d p2=%0d want 3 3", HP_P1, HP_P2);
    end
    n_checks++;
    if (HP_IN !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hp_in: got %b want 00", HP_IN);
    end
    n_checks++;
    if (CNT1S !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt1s: got %b want 0", CNT1S);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_good_dwell();
    step(4'h4);
    step(4'h4);
    for (int c = 1; c <= 16; c++) begin
      step(4'h8);
      n_checks++;
      if ({CNT1S, HP_IN, HP_P1, HP_P2} !== exp_all()) begin
        n_fail++;
        $display("FAIL good_dwell_model c=%0d: got %b want %b", c,
                 {CNT1S, HP_IN, HP_P1, HP_P2}, exp_all());
      end
      if (c == 1) begin
        n_checks++;
        if (HP_P2 !== 3'd2) begin
          n_fail++;
          $display("FAIL good_dmg_latency: got p2=%0d want 2", HP_P2);
        end
      end
      if (c >= 8 && c <= 15) begin
        n_checks++;
        if (CNT1S !== (c == 8)) begin
          n_fail++;
          $display("FAIL good_pulse c=%0d: got %b want %b", c, CNT1S, c == 8);
        end
      end
    end
    step(4'h2);
  endtask

  task automatic test_knockout();
    logic [3:0] seq [6] = '{4'h2, 4'h8, 4'h2, 4'h8, 4'h2, 4'h8};
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if ({CNT1S, HP_IN, HP_P1, HP_P2} !== exp_all()) begin
        n_fail++;
        $display("FAIL knockout_model i=%0d: got %b want %b", i,
                 {CNT1S, HP_IN, HP_P1, HP_P2}, exp_all());
      end
      if (i == 3) begin
        n_checks++;
        if (HP_P2 !== 3'd0 || HP_IN !== 2'b01) begin
          n_fail++;
          $display("FAIL knockout_out: got p2=%0d hp_in=%b want 0 01", HP_P2, HP_IN);
        end
      end
    end
    n_checks++;
    if (HP_P2 !== 3'd0) begin
      n_fail++;
      $display("FAIL knockout_saturate: got p2=%0d want 0", HP_P2);
    end
    step(4'hA);
    step(4'h2);
    n_checks++;
    if (HP_P1 !== 3'd3 || HP_P2 !== 3'd3 || HP_IN !== 2'b00) begin
      n_fail++;
      $display("FAIL win_restart: got p1=%0d p2=%0d hp_in=%b want 3 3 00",
               HP_P1, HP_P2, HP_IN);
    end
  endtask

  task automatic test_ouch();
    logic [3:0] seq [6] = '{4'h9, 4'h2, 4'h9, 4'h2, 4'h9, 4'h2};
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if ({CNT1S, HP_IN, HP_P1, HP_P2} !== exp_all()) begin
        n_fail++;
        $display("FAIL ouch_model i=%0d: got %b want %b", i,
                 {CNT1S, HP_IN, HP_P1, HP_P2}, exp_all());
      end
    end
    n_checks++;
    if (HP_P1 !== 3'd0 || HP_IN !== 2'b10) begin
      n_fail++;
      $display("FAIL ouch_out: got p1=%0d hp_in=%b want 0 10", HP_P1, HP_IN);
    end
    step(4'hB);
    step(4'h2);
    n_checks++;
    if (HP_P1 !== 3'd3 || HP_P2 !== 3'd3) begin
      n_fail++;
      $display("FAIL lose_restart: got p1=%0d p2=%0d want 3 3", HP_P1, HP_P2);
    end
    step(4'h9);
    step(4'h7);
    step(4'h4);
    step(4'h2);
    n_checks++;
    if (HP_P1 !== 3'd2 || HP_P2 !== 3'd3) begin
      n_fail++;
      $display("FAIL wrong_no_reload: got p1=%0d p2=%0d want 2 3", HP_P1, HP_P2);
    end
  endtask

  task automatic test_abort_and_chain();
    int pulses = 0;
    step(4'h2);
    for (int c = 0; c < 3; c++) begin
      step(4'h8);
      pulses += int'(CNT1S);
    end
    step(4'h2);
    pulses += int'(CNT1S);
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses);
    end
    for (int c = 1; c <= 11; c++) begin
      step(4'h8);
      n_checks++;
      if (CNT1S !== (c == 8)) begin
        n_fail++;
        $display("FAIL reentry_pulse c=%0d: got %b want %b", c, CNT1S, c == 8);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      step(4'hA);
      n_checks++;
      if (CNT1S !== (c == 8)) begin
        n_fail++;
        $display("FAIL chain_pulse c=%0d: got %b want %b", c, CNT1S, c == 8);
      end
    end
    step(4'h2);
  endtask

  task automatic test_reset_mid_dwell();
    int pulses = 0;
    step(4'h2);
    for (int c = 0; c < 5; c++) begin
      step(4'h8);
      pulses += int'(CNT1S);
    end
    RST = 1'b1;
    #1;
    model_reset();
    pulses += int'(CNT1S);
    n_checks++;
    if (pulses != 0 || HP_P1 !== 3'd3 || HP_P2 !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid_dwell: got pulses=%0d p1=%0d p2=%0d want 0 3 3",
               pulses, HP_P1, HP_P2);
    end
    STATE = 4'h2;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    n_checks++;
    if (CNT1S !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_pulse: got %b want 0", CNT1S);
    end
    @(negedge CLK);
    RST = 1'b0;
    step(4'h2);
    for (int c = 1; c <= 9; c++) begin
      step(4'h8);
      n_checks++;
      if (CNT1S !== (c == 8) || HP_P2 !== 3'd2) begin
        n_fail++;
        $display("FAIL post_reset_dwell c=%0d: got pulse=%b p2=%0d want %b 2",
                 c, CNT1S, HP_P2, c == 8);
      end
    end
    step(4'h2);
  endtask

  task automatic test_random();
    logic [3:0] codes [9] = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [3:0] s;
    int         hold;
    int         errs = 0;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) < 8) s = codes[$urandom_range(0, 8)];
      else s = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 20);
      for (int h = 0; h < hold; h++) begin
        step(s);
        n_checks++;
        if ({CNT1S, HP_IN, HP_P1, HP_P2} !== exp_all()) begin
          n_fail++;
          errs++;
          if (errs <= 10)
            $display("FAIL random t=%0d h=%0d state=%h: got %b want %b", t, h, s,
                     {CNT1S, HP_IN, HP_P1, HP_P2}, exp_all());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_dwell();
    test_knockout();
    test_ouch();
    test_abort_and_chain();
    test_reset_mid_dwell();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
